// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if : EX-stage <-> divide sequencer bundle.
//
// Signals (direction seen from the divider, i.e. the slave modport):
//   start_i     in   EX requests a divide, held until ready_o is seen
//   annul_i     in   cancel any in-flight divide (flush / exception)
//   signed_i    in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i   in   dividend
//   opdata2_i   in   divisor
//   result_o    out  {remainder, quotient} -> {HI, LO}
//   ready_o     out  result_o valid
//   stall_req_o out  freeze IF/ID/EX while the divide is outstanding
//   busy_o      out  divider is iterating or handling divide-by-zero
//
// master : EX side (drives requests, observes results)
// slave  : divider side
// ---------------------------------------------------------------------------
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  start_i;
  logic                  annul_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stall_req_o;
  logic                  busy_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_req_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_req_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : multi-cycle radix-2 restoring divider for DIV / DIVU.
//
// Captures operands from EX on start, iterates once per clock for DATA_W
// clocks, applies the sign fix-up and presents {remainder, quotient} until
// EX drops start. A zero divisor short-circuits to a zero result.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous reset, active-low
//   bus    div_if.slave  request/result bundle (see div_if.sv)
//
// Parameters:
//   DATA_W  operand width
//   CNT_W   iteration counter width (must be able to hold DATA_W)
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  div_if.slave   bus
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t                state_reg,  state_next;
  logic [CNT_W-1:0]      cnt_reg,    cnt_next;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [DATA_W-1:0]     dq_reg,     dq_next;
  logic [DATA_W-1:0]     rem_reg,    rem_next;
  logic [DATA_W-1:0]     dsr_reg,    dsr_next;
  logic                  neg_q_reg,  neg_q_next;
  logic                  neg_r_reg,  neg_r_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  // The partial remainder is always below the divisor, so DATA_W+1 bits hold it.
  logic [DATA_W:0]       partial;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  assign partial = {rem_reg, dq_reg[DATA_W-1]};
  assign diff    = partial - {1'b0, dsr_reg};

  // 0x80000000 is treated as the unsigned magnitude 2^31 throughout, so
  // the most-negative / -1 case simply wraps.
  assign quo_fix = neg_q_reg ? (~dq_reg + 1'b1)  : dq_reg;
  assign rem_fix = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= FREE;
      cnt_reg    <= '0;
      dq_reg     <= '0;
      rem_reg    <= '0;
      dsr_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dq_reg     <= dq_next;
      rem_reg    <= rem_next;
      dsr_reg    <= dsr_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dq_next     = dq_reg;
    rem_next    = rem_reg;
    dsr_next    = dsr_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;

    case (state_reg)
      FREE: begin
        result_next = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_next = BY_ZERO;
          end else begin
            state_next = ON;
            cnt_next   = '0;
            rem_next   = '0;
            dq_next    = (bus.signed_i && bus.opdata1_i[DATA_W-1])
                         ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
            dsr_next   = (bus.signed_i && bus.opdata2_i[DATA_W-1])
                         ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
            neg_q_next = bus.signed_i
                         & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_r_next = bus.signed_i & bus.opdata1_i[DATA_W-1];
          end
        end
      end

      BY_ZERO: begin
        state_next  = END;
        result_next = '0;
      end

      ON: begin
        if (cnt_reg != CNT_W'(DATA_W)) begin
          // diff MSB clear means the trial subtraction did not underflow.
          dq_next  = {dq_reg[DATA_W-2:0], ~diff[DATA_W]};
          rem_next = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
          cnt_next = cnt_reg + 1'b1;
        end else begin
          result_next = {rem_fix, quo_fix};
          state_next  = END;
        end
      end

      END: begin
        if (!bus.start_i) begin
          state_next  = FREE;
          result_next = '0;
        end
      end

      default: begin
        state_next  = FREE;
        result_next = '0;
      end
    endcase

    // Flush wins over everything, including a fresh start in FREE.
    if (bus.annul_i) begin
      state_next  = FREE;
      cnt_next    = '0;
      result_next = '0;
    end
  end

  assign bus.result_o    = result_reg;
  assign bus.ready_o     = (state_reg == END);
  // Drops as soon as END is reached so EX samples result_o on that edge.
  assign bus.stall_req_o = bus.start_i & ~bus.annul_i & (state_reg != END);
  assign bus.busy_o      = (state_reg == ON) | (state_reg == BY_ZERO);

endmodule
